mcast_arbiter_n: RTL and testbench
==================================

Name: mcast_arbiter_n

Overview:
N-port multicast switch arbiter with packet-level locking, the parametrised successor to the fixed 4-port all-or-nothing arbiter. Each input presents a one-hot/multi-hot destination mask. A packet is granted only if it wins every requested output. Once granted, the outputs stay locked to that input until its last beat transfers. Sits between the per-port input buffers and the output crossbar muxes. Adds selectable pointer rotation and age-based anti-starvation with output reservation.

Parameters:
NUM_PORTS, 4, number of inputs and outputs (>=2)
SEL_W, $clog2(NUM_PORTS), mux select width per output
ROTATE_MODE, 1, 0 = common pointer advances every cycle; 1 = advances only on a cycle that issues a grant
AGE_LIMIT, 16, wait cycles before a requester becomes urgent (>=1)
AGE_W, $clog2(AGE_LIMIT+1), age counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  NUM_PORTS  input i has a head beat
in_last  in  NUM_PORTS  head beat of input i is end of packet
in_dst  in  NUM_PORTS*NUM_PORTS  dst mask of input i at [i*N +: N]; stable while valid and unheld
out_ready  in  NUM_PORTS  output j can accept a beat
grant  out  NUM_PORTS  registered; input i owns its locked outputs
beat_en  out  NUM_PORTS  comb; grant[i] & in_valid[i] & all out_ready over held_mask[i]; input i pops a beat
mux_sel  out  NUM_PORTS*SEL_W  registered; source input for output j
out_active  out  NUM_PORTS  registered; output j locked to an owner
out_valid  out  NUM_PORTS  comb; out_active[j] & beat_en[owner j]

Behaviour:
- Reset (async): grant=0, mux_sel=0, out_active=0, ptr=0, all held_mask=0, age=0, urgent=none. Combinational outputs are therefore 0.
- Per-input state: IDLE / HOLD (grant[i]). busy = OR of held_mask over HOLD inputs.
- Candidate i: in_valid[i] & IDLE & in_dst[i]!=0 & (in_dst[i] & busy)==0 & (in_dst[i] & reserved)==0, unless i is the urgent port. in_dst==0 requests are ignored, never granted, and not aged.
- Per-output winner: the first candidate requesting j, scanning from ptr modulo N. If an urgent port exists it replaces ptr as the scan start.
- Grant rule: candidate i is granted iff it wins every output in in_dst[i] (all-or-nothing). Multiple disjoint grants are allowed in one cycle.
- On grant, next edge: grant[i]=1, held_mask[i]=in_dst[i], and for every j in the mask mux_sel[j]=i and out_active[j]=1. Grant latency is 1 cycle from request; the first beat_en is possible in the cycle grant rises.
- Transfer: a beat moves when beat_en[i]=1. Multicast beats move only when all destinations are ready. There is no partial delivery.
- Release: beat_en[i] & in_last[i] puts the input in IDLE next edge. Its outputs clear out_active at the same edge. Freed outputs are re-arbitrated from the next cycle, giving exactly one idle cycle per output between packets.
- A single-beat packet (in_last on first beat) holds for exactly one cycle.
- mux_sel keeps its last value when out_active=0.
- Pointer:
  - ROTATE_MODE=0: ptr+1 every cycle.
  - ROTATE_MODE=1: ptr+1 only on cycles with >=1 grant.
  - Wraps N-1 -> 0 (modulo for non-power-of-2 N).
- Aging:
  - age[i] increments (saturating at AGE_LIMIT) while in_valid & IDLE & dst!=0 & not granted.
  - age[i] clears on grant or when !in_valid.
  - When no urgent port exists, the lowest-index i with age==AGE_LIMIT becomes urgent.
  - While urgent, its in_dst outputs are reserved: no other input may be granted them. Already-held outputs drain normally.
  - Urgent clears on its grant, or if it drops in_valid.
- Reset mid-packet: all locks drop immediately and the pointer restarts at 0. Upstream buffers are reset by the same rst_n.
- Deadlock freedom: every lock releases on in_last; reservation guarantees an urgent port is granted within one max packet length after becoming urgent.

Decomposition:
- packet_pkg gains NUM_PORTS-derived SEL_W, the arbiter state enum, and a port_mask_t typedef.
- Sub-module rr_pick_n (NUM_PORTS): combinational rotating-priority picker (req vector, start index -> one-hot winner). It is instantiated once per output.

Test Plan:
- N=4, mode 1: in0 dst 0011 and in2 dst 0100 both valid, 3-beat packets, all ready -> both granted at cycle 1; mux_sel0=mux_sel1=0, mux_sel2=2; release after the 3rd beat.
- N=4: in0 dst 0011, in1 dst 0010, ptr=1 -> in1 wins output1, in0 denied (all-or-nothing), out_active0 stays 0; in0 granted the cycle after in1's last beat plus 1.
- Multicast stall: in3 dst 1001, out_ready=0001 for 4 cycles -> beat_en3=0 and out_valid=0 on both outputs; beat moves the cycle out_ready=1001.
- Starvation, AGE_LIMIT=4: in0 dst 0011 while in1 (dst 0001) and in2 (dst 0010) alternate back-to-back packets -> in0 becomes urgent after 4 waiting cycles; outputs 0 and 1 are reserved; in0 granted once both drain.
- N=5 parameter sweep, mode 0: ptr wraps 4->0; in_dst=00000 with valid -> never granted, age stays 0.
- Async reset asserted mid-packet -> grant, out_active, and mux_sel at 0 immediately; fresh arbitration works after deassert.

Source files
------------

// File: rtl/mcast_arbiter_n_pkg.sv
// rtl/mcast_arbiter_n_pkg.sv - shared types and helpers for the multicast arbiter
package mcast_arbiter_n_pkg;

  localparam int DEF_NUM_PORTS = 4;
  localparam int DEF_SEL_W     = $clog2(DEF_NUM_PORTS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

  typedef logic [DEF_NUM_PORTS-1:0] port_mask_t;

  // Single-step modulo; callers never exceed 2*n-1.
  function automatic int wrap_idx(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/mcast_arbiter_n_rr_pick.sv
// rtl/mcast_arbiter_n_rr_pick.sv - rotating-priority picker, one-hot winner from a start index
module rr_pick_n
  import mcast_arbiter_n_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int SEL_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [SEL_W-1:0]     start,
  output logic [NUM_PORTS-1:0] win
);

  logic             found;
  logic [SEL_W-1:0] idx;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = SEL_W'(wrap_idx(int'(start) + k, NUM_PORTS));
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mcast_arbiter_n.sv
// rtl/mcast_arbiter_n.sv - N-port all-or-nothing multicast arbiter with packet locking,
// selectable pointer rotation and age-based output reservation.
module mcast_arbiter_n
  import mcast_arbiter_n_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int SEL_W       = $clog2(NUM_PORTS),
  parameter int ROTATE_MODE = 1,
  parameter int AGE_LIMIT   = 16,
  parameter int AGE_W       = $clog2(AGE_LIMIT + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS-1:0]           in_valid,
  input  logic [NUM_PORTS-1:0]           in_last,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] in_dst,
  input  logic [NUM_PORTS-1:0]           out_ready,
  output logic [NUM_PORTS-1:0]           grant,
  output logic [NUM_PORTS-1:0]           beat_en,
  output logic [NUM_PORTS*SEL_W-1:0]     mux_sel,
  output logic [NUM_PORTS-1:0]           out_active,
  output logic [NUM_PORTS-1:0]           out_valid
);

  localparam int N = NUM_PORTS;
  typedef logic [N-1:0]     mask_t;
  typedef logic [SEL_W-1:0] sel_t;

  arb_state_e       state_q   [N];
  arb_state_e       state_d   [N];
  mask_t            held_q    [N];
  mask_t            held_d    [N];
  sel_t             mux_sel_q [N];
  sel_t             mux_sel_d [N];
  logic [AGE_W-1:0] age_q     [N];
  logic [AGE_W-1:0] age_d     [N];
  mask_t            out_active_q, out_active_d;
  sel_t             ptr_q, ptr_d;
  logic             urg_valid_q, urg_valid_d;
  sel_t             urg_idx_q, urg_idx_d;

  mask_t dst     [N];
  mask_t req_col [N];
  mask_t win_col [N];
  mask_t hold_vec, busy, reserved, cand, granted, rls;
  sel_t  scan_start;

  for (genvar i = 0; i < N; i++) begin : g_in
    assign dst[i]      = in_dst[i*N +: N];
    assign hold_vec[i] = (state_q[i] == ST_HOLD);
    assign beat_en[i]  = hold_vec[i] && in_valid[i] && ((held_q[i] & ~out_ready) == '0);
  end

  assign rls = beat_en & in_last;

  always_comb begin
    busy = '0;
    for (int i = 0; i < N; i++) begin
      if (hold_vec[i]) busy = busy | held_q[i];
    end
    reserved   = urg_valid_q ? dst[urg_idx_q] : '0;
    scan_start = urg_valid_q ? urg_idx_q : ptr_q;
    // The urgent port is exempt from its own reservation.
    for (int i = 0; i < N; i++) begin
      cand[i] = in_valid[i] && !hold_vec[i] && (dst[i] != '0) && ((dst[i] & busy) == '0) &&
                ((urg_valid_q && (urg_idx_q == sel_t'(i))) || ((dst[i] & reserved) == '0));
    end
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) begin
        req_col[j][i] = cand[i] && dst[i][j];
      end
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_out
    rr_pick_n #(.NUM_PORTS(N), .SEL_W(SEL_W)) u_pick (
      .req   (req_col[j]),
      .start (scan_start),
      .win   (win_col[j])
    );
    assign mux_sel[j*SEL_W +: SEL_W] = mux_sel_q[j];
    assign out_valid[j] = out_active_q[j] && beat_en[mux_sel_q[j]];
  end

  // All-or-nothing: a candidate must win every output it asks for.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      granted[i] = cand[i];
      for (int j = 0; j < N; j++) begin
        if (dst[i][j] && !win_col[j][i]) granted[i] = 1'b0;
      end
    end
  end

  always_comb begin
    out_active_d = out_active_q;
    for (int j = 0; j < N; j++) begin
      mux_sel_d[j] = mux_sel_q[j];
      if (out_active_q[j] && rls[mux_sel_q[j]]) out_active_d[j] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      held_d[i]  = held_q[i];
      if (granted[i]) begin
        state_d[i] = ST_HOLD;
        held_d[i]  = dst[i];
        for (int j = 0; j < N; j++) begin
          if (dst[i][j]) begin
            mux_sel_d[j]    = sel_t'(i);
            out_active_d[j] = 1'b1;
          end
        end
      end else if (rls[i]) begin
        state_d[i] = ST_IDLE;
        held_d[i]  = '0;
      end
    end

    ptr_d = ptr_q;
    if ((ROTATE_MODE == 0) || (granted != '0)) begin
      ptr_d = (int'(ptr_q) == N - 1) ? '0 : ptr_q + sel_t'(1);
    end

    urg_valid_d = urg_valid_q;
    urg_idx_d   = urg_idx_q;
    for (int i = 0; i < N; i++) begin
      age_d[i] = age_q[i];
      if (!in_valid[i] || granted[i] || hold_vec[i] || (dst[i] == '0)) begin
        age_d[i] = '0;
      end else if (age_q[i] < AGE_W'(AGE_LIMIT)) begin
        age_d[i] = age_q[i] + AGE_W'(1);
      end
    end
    if (urg_valid_q) begin
      if (granted[urg_idx_q] || !in_valid[urg_idx_q]) urg_valid_d = 1'b0;
    end else begin
      // Descending scan so the lowest aged index ends up selected.
      for (int i = N - 1; i >= 0; i--) begin
        if ((age_q[i] == AGE_W'(AGE_LIMIT)) && in_valid[i] && !granted[i]) begin
          urg_valid_d = 1'b1;
          urg_idx_d   = sel_t'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        state_q[i]   <= ST_IDLE;
        held_q[i]    <= '0;
        mux_sel_q[i] <= '0;
        age_q[i]     <= '0;
      end
      out_active_q <= '0;
      ptr_q        <= '0;
      urg_valid_q  <= 1'b0;
      urg_idx_q    <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        state_q[i]   <= state_d[i];
        held_q[i]    <= held_d[i];
        mux_sel_q[i] <= mux_sel_d[i];
        age_q[i]     <= age_d[i];
      end
      out_active_q <= out_active_d;
      ptr_q        <= ptr_d;
      urg_valid_q  <= urg_valid_d;
      urg_idx_q    <= urg_idx_d;
    end
  end

  assign grant      = hold_vec;
  assign out_active = out_active_q;

endmodule

// File: tb/tb_mcast_arbiter_n.sv
// tb/tb_mcast_arbiter_n.sv - directed self-checking bench for mcast_arbiter_n (N=4 mode 1, N=5 mode 0)
module tb_mcast_arbiter_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  in_valid, in_last, out_ready, grant, beat_en, out_active, out_valid;
  logic [15:0] in_dst;
  logic [7:0]  mux_sel;

  logic [4:0]  v5, l5, r5, g5, b5, a5, o5;
  logic [24:0] d5;
  logic [14:0] m5;

  int n_checks = 0;
  int n_errors = 0;

  mcast_arbiter_n #(.NUM_PORTS(4), .ROTATE_MODE(1), .AGE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .in_dst(in_dst),
    .out_ready(out_ready), .grant(grant), .beat_en(beat_en), .mux_sel(mux_sel),
    .out_active(out_active), .out_valid(out_valid)
  );

  mcast_arbiter_n #(.NUM_PORTS(5), .ROTATE_MODE(0)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_last(l5), .in_dst(d5),
    .out_ready(r5), .grant(g5), .beat_en(b5), .mux_sel(m5),
    .out_active(a5), .out_valid(o5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_valid = '0; in_last = '0; in_dst = '0; out_ready = 4'b1111;
    v5 = '0; l5 = '0; d5 = '0; r5 = 5'b11111;

    #12;
    check("rst_grant", grant, 4'b0000);
    check("rst_out_active", out_active, 4'b0000);
    check("rst_mux_sel", mux_sel, 8'h00);
    check("rst_beat_en", beat_en, 4'b0000);
    check("rst_out_valid", out_valid, 4'b0000);
    check("rst_grant5", g5, 5'b00000);

    @(posedge clk);
    #1 rst_n = 1'b1;

    // N=5 mode 0: ptr equals cycle count mod 5; in0 valid with empty mask throughout
    v5 = 5'b00001;
    for (int k = 0; k < 4; k++) begin
      #1 check("t5_idle_grant", g5, 5'b00000);
      tick();
    end
    v5 = 5'b11111; l5 = 5'b11111;
    d5 = {5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00000};
    tick();
    v5 = 5'b10001;
    #1 check("t5_ptr4_grant", g5, 5'b10000);
    check("t5_ptr4_sel", m5[2:0], 3'd4);
    check("t5_ptr4_beat", b5, 5'b10000);
    check("t5_ptr4_oval", o5, 5'b00001);
    tick();
    v5 = 5'b00001;
    #1 check("t5_release", g5, 5'b00000);
    tick();
    tick();
    v5 = 5'b11111;
    tick();
    v5 = 5'b01001;
    #1 check("t5_wrap_grant", g5, 5'b01000);
    check("t5_wrap_sel", m5[2:0], 3'd3);
    check("t5_wrap_beat", b5, 5'b01000);
    tick();
    v5 = 5'b00001;
    #1 check("t5_zero_dst_never", g5, 5'b00000);
    v5 = '0; l5 = '0; d5 = '0;
    tick();

    // Two disjoint packets granted together
    in_valid = 4'b0101; in_last = 4'b0000; in_dst = 16'h0403;
    #1 check("t1_latency", grant, 4'b0000);
    tick();
    #1 check("t1_grant", grant, 4'b0101);
    check("t1_out_active", out_active, 4'b0111);
    check("t1_mux_sel", mux_sel, 8'h20);
    check("t1_beat_en", beat_en, 4'b0101);
    check("t1_out_valid", out_valid, 4'b0111);
    tick();
    tick();
    in_last = 4'b0101;
    #1 check("t1_last_beat", beat_en, 4'b0101);
    tick();
    in_valid = '0; in_last = '0;
    #1 check("t1_release", grant, 4'b0000);
    check("t1_rel_active", out_active, 4'b0000);
    check("t1_sel_kept", mux_sel, 8'h20);
    tick();

    // ptr=1: in1 takes output1, in0 denied all-or-nothing
    in_valid = 4'b0011; in_dst = 16'h0023;
    tick();
    #1 check("t2_grant", grant, 4'b0010);
    check("t2_out_active", out_active, 4'b0010);
    check("t2_mux_sel", mux_sel, 8'h24);
    tick();
    in_last = 4'b0010;
    #1 check("t2_last", beat_en, 4'b0010);
    tick();
    in_valid = 4'b0001; in_last = 4'b0000;
    #1 check("t2_gap_grant", grant, 4'b0000);
    check("t2_gap_active", out_active, 4'b0000);
    tick();
    in_last = 4'b0001;
    #1 check("t2_in0_grant", grant, 4'b0001);
    check("t2_in0_active", out_active, 4'b0011);
    check("t2_in0_sel", mux_sel, 8'h20);
    check("t2_single_beat", beat_en, 4'b0001);
    tick();
    in_valid = '0; in_last = '0;
    #1 check("t2_single_rel", grant, 4'b0000);

    // Multicast stall until both destinations are ready
    in_valid = 4'b1000; in_last = 4'b1000; in_dst = 16'h9000;
    tick();
    out_ready = 4'b0001;
    #1 check("t3_mux_sel", mux_sel, 8'hE3);
    check("t3_out_active", out_active, 4'b1001);
    for (int k = 0; k < 4; k++) begin
      #1 check("t3_stall_beat", beat_en, 4'b0000);
      check("t3_stall_oval", out_valid, 4'b0000);
      check("t3_stall_grant", grant, 4'b1000);
      tick();
    end
    out_ready = 4'b1111;
    #1 check("t3_move_beat", beat_en, 4'b1000);
    check("t3_move_oval", out_valid, 4'b1001);
    tick();
    in_valid = '0; in_last = '0;
    #1 check("t3_release", grant, 4'b0000);
    check("t3_rel_active", out_active, 4'b0000);
    tick();

    // Starvation: in0 ages out and reserves outputs 0 and 1
    in_valid = 4'b0110; in_dst = 16'h0210;
    tick();
    in_valid = 4'b0111; in_dst = 16'h0213;
    #1 check("t4_first_pair", grant, 4'b0110);
    tick();
    in_last = 4'b0110;
    #1 check("t4_pair_last", beat_en, 4'b0110);
    tick();
    in_last = 4'b0000;
    #1 check("t4_gap1", grant, 4'b0000);
    tick();
    #1 check("t4_rivals_again", grant, 4'b0110);
    tick();
    in_last = 4'b0110;
    tick();
    in_last = 4'b0000;
    #1 check("t4_gap2", grant, 4'b0000);
    tick();
    in_valid = 4'b0001; in_last = 4'b0001;
    #1 check("t4_urgent_grant", grant, 4'b0001);
    check("t4_urgent_active", out_active, 4'b0011);
    check("t4_urgent_sel", mux_sel, 8'hE0);
    check("t4_urgent_beat", beat_en, 4'b0001);
    tick();
    in_valid = '0; in_last = '0;
    #1 check("t4_release", grant, 4'b0000);
    tick();

    // Async reset mid-packet, then fresh arbitration from ptr 0
    in_valid = 4'b0100; in_last = 4'b0100; in_dst = 16'h0400;
    tick();
    in_valid = 4'b0101; in_dst = 16'h0403;
    #1 check("t6_pre_in2", grant, 4'b0100);
    tick();
    in_valid = 4'b0001; in_last = 4'b0000;
    #1 check("t6_pre_in0", grant, 4'b0001);
    check("t6_pre_active", out_active, 4'b0011);
    #2 rst_n = 1'b0;
    #1 check("t6_rst_grant", grant, 4'b0000);
    check("t6_rst_active", out_active, 4'b0000);
    check("t6_rst_mux_sel", mux_sel, 8'h00);
    check("t6_rst_beat", beat_en, 4'b0000);
    check("t6_rst_oval", out_valid, 4'b0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    in_valid = 4'b0011; in_dst = 16'h0023;
    tick();
    #1 check("t6_fresh_grant", grant, 4'b0001);
    check("t6_fresh_active", out_active, 4'b0011);
    in_valid = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
